// File: rtl/alu_cmd_ctrl.sv
// Command-frame parser and result returner for the registered ALU: decodes CC/DD
// frames from the RX byte stream, issues one ALU op, sends the result LSB first.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    FUN_WIDTH     = 4,
    parameter int                    TIMEOUT       = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOPER = 8'hDD
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic                    ALU_CLK_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    FIFO_FULL,
    output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
    output logic                    FIFO_WR_INC,
    output logic                    CTRL_BUSY
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_ISSUE,
        S_WAIT,
        S_SEND_LSB,
        S_SEND_MSB
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [FUN_WIDTH-1:0]    r_alu_fun;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic [CNT_W-1:0]        r_wait_cnt;

    logic w_ld_a;
    logic w_ld_b;
    logic w_ld_fun;
    logic w_capture;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bytes arriving outside the receive states fall through the default hold.
    always_comb begin
        w_next       = r_state;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_fun     = 1'b0;
        w_capture    = 1'b0;
        ALU_EN       = 1'b0;
        ALU_CLK_EN   = 1'b0;
        FIFO_WR_INC  = 1'b0;
        FIFO_WR_DATA = '0;
        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OPER) begin
                        w_next = S_GET_A;
                    end else if (RX_P_DATA == CMD_ALU_NOPER) begin
                        w_next = S_GET_FUN;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    w_ld_a = 1'b1;
                    w_next = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    w_ld_b = 1'b1;
                    w_next = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    w_ld_fun = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ALU_EN     = 1'b1;
                ALU_CLK_EN = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                ALU_CLK_EN = 1'b1;
                // A missing OUT_VALID (compare false, unflagged op) still completes.
                if (OUT_VALID || (r_wait_cnt == CNT_LAST)) begin
                    w_capture = 1'b1;
                    w_next    = S_SEND_LSB;
                end
            end
            S_SEND_LSB: begin
                FIFO_WR_DATA = r_result[DATA_WIDTH-1:0];
                FIFO_WR_INC  = !FIFO_FULL;
                if (!FIFO_FULL) begin
                    w_next = S_SEND_MSB;
                end
            end
            S_SEND_MSB: begin
                FIFO_WR_DATA = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                FIFO_WR_INC  = !FIFO_FULL;
                if (!FIFO_FULL) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_result   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_ld_a) begin
                r_alu_a <= RX_P_DATA;
            end
            if (w_ld_b) begin
                r_alu_b <= RX_P_DATA;
            end
            if (w_ld_fun) begin
                r_alu_fun <= RX_P_DATA[FUN_WIDTH-1:0];
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_capture) begin
                r_result <= ALU_OUT;
            end
        end
    end

    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign CTRL_BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames with literal results plus random traffic,
// every cycle compared against a frame/timestamp-level model of the controller.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
    localparam int DW = 8;
    localparam int FW = 4;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic [DW-1:0] ALU_A;
    logic [DW-1:0] ALU_B;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_EN;
    logic          ALU_CLK_EN;
    logic [2*DW-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic          FIFO_FULL = 1'b0;
    logic [DW-1:0] FIFO_WR_DATA;
    logic          FIFO_WR_INC;
    logic          CTRL_BUSY;

    logic          spur = 1'b0;
    logic [2*DW-1:0] alu_res;
    logic          alu_vld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    int         fq[$];
    logic [7:0] wq[$];
    bit         m_exec = 0;
    bit         m_cap = 0;
    int         m_issue = 0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [3:0] m_fun = '0;

    // logs for the directed literal checks
    logic [7:0] wlog[$];
    int         en_cnt = 0;
    int         clken_cnt = 0;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(
        .DATA_WIDTH(DW), .FUN_WIDTH(FW), .TIMEOUT(TO),
        .CMD_ALU_OPER(8'hCC), .CMD_ALU_NOPER(8'hDD)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_CLK_EN(ALU_CLK_EN), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .FIFO_FULL(FIFO_FULL), .FIFO_WR_DATA(FIFO_WR_DATA),
        .FIFO_WR_INC(FIFO_WR_INC), .CTRL_BUSY(CTRL_BUSY)
    );

    assign ALU_OUT   = alu_res;
    assign OUT_VALID = alu_vld | spur;

    // Registered ALU: compares and op F are unflagged when they yield nothing.
    function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        int   ia;
        int   ib;
        int   r;
        logic v;
        ia = int'(a);
        ib = int'(b);
        v  = 1'b1;
        r  = 0;
        case (f)
            4'h0: r = ia + ib;
            4'h1: r = ia - ib;
            4'h2: r = ia * ib;
            4'h3: r = (ib == 0) ? 0 : ia / ib;
            4'h4: r = ia & ib;
            4'h5: r = ia | ib;
            4'h6: r = ~(ia & ib) & 'hFF;
            4'h7: r = ~(ia | ib) & 'hFF;
            4'h8: r = ia ^ ib;
            4'h9: r = ~(ia ^ ib) & 'hFF;
            4'hA: begin v = (ia == ib); r = v ? 1 : 0; end
            4'hB: begin v = (ia > ib);  r = v ? 1 : 0; end
            4'hC: begin v = (ia < ib);  r = v ? 1 : 0; end
            4'hD: r = ia >> 1;
            4'hE: r = ia << 1;
            default: begin v = 1'b0; r = 0; end
        endcase
        return {v, r[15:0]};
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_res <= '0;
            alu_vld <= 1'b0;
        end else begin
            alu_vld <= 1'b0;
            if (ALU_EN && ALU_CLK_EN) begin
                {alu_vld, alu_res} <= alu_f(ALU_A, ALU_B, ALU_FUN);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: receive progress is a queue of pending fields; execution is tracked by
    // the issue timestamp, a capture flag and the queue of bytes still to be written.
    always @(negedge CLK) begin : cmp
        bit         recv;
        bit         idle;
        bit         in_issue;
        bit         in_wait;
        bit         sending;
        logic [7:0] e_data;
        cyc++;
        if (!RST) begin
            fq.delete();
            wq.delete();
            m_exec = 0;
            m_cap  = 0;
            m_a    = '0;
            m_b    = '0;
            m_fun  = '0;
            check("reset_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, ALU_CLK_EN,
                  FIFO_WR_INC, CTRL_BUSY, FIFO_WR_DATA}, 64'd0);
        end else begin
            recv     = (fq.size() != 0);
            idle     = !m_exec && !recv;
            in_issue = m_exec && (cyc == m_issue);
            in_wait  = m_exec && !m_cap && (cyc > m_issue);
            sending  = m_exec && m_cap;
            e_data   = sending ? wq[0] : 8'h00;
            check("alu_a", ALU_A, m_a);
            check("alu_b", ALU_B, m_b);
            check("alu_fun", ALU_FUN, m_fun);
            check("alu_en", ALU_EN, in_issue);
            check("alu_clk_en", ALU_CLK_EN, in_issue || in_wait);
            check("ctrl_busy", CTRL_BUSY, !idle);
            check("fifo_wr_inc", FIFO_WR_INC, sending && !FIFO_FULL);
            check("fifo_wr_data", FIFO_WR_DATA, e_data);

            if (RX_D_VLD && idle) begin
                if (RX_P_DATA == 8'hCC)      fq = '{1, 2, 3};
                else if (RX_P_DATA == 8'hDD) fq = '{3};
            end else if (RX_D_VLD && recv) begin
                case (fq[0])
                    1:       m_a = RX_P_DATA;
                    2:       m_b = RX_P_DATA;
                    default: m_fun = RX_P_DATA[3:0];
                endcase
                void'(fq.pop_front());
                if (fq.size() == 0) begin
                    m_exec  = 1;
                    m_cap   = 0;
                    m_issue = cyc + 1;
                end
            end
            if (in_wait && (OUT_VALID || (cyc - m_issue == TO))) begin
                m_cap = 1;
                wq    = '{ALU_OUT[7:0], ALU_OUT[15:8]};
            end else if (sending && !FIFO_FULL) begin
                void'(wq.pop_front());
                if (wq.size() == 0) begin
                    m_exec = 0;
                    m_cap  = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (FIFO_WR_INC) wlog.push_back(FIFO_WR_DATA);
            if (ALU_EN) en_cnt++;
            if (ALU_CLK_EN) clken_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (CTRL_BUSY && n < 200) begin
            tick();
            n++;
        end
        check(name, (n < 200), 1);
    endtask

    task automatic start_log();
        wlog.delete();
        en_cnt    = 0;
        clken_cnt = 0;
    endtask

    task automatic expect_writes(input string name, input logic [7:0] b0, input logic [7:0] b1);
        check({name, "_count"}, wlog.size(), 2);
        while (wlog.size() < 2) wlog.push_back(8'hxx);
        check({name, "_lsb"}, wlog[0], b0);
        check({name, "_msb"}, wlog[1], b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2 RST = 1'b1;
        tick();
        check("reset_busy", CTRL_BUSY, 0);
        check("reset_alu_a", ALU_A, 8'h00);

        // ADD 5+3
        start_log();
        rx(8'hCC); rx(8'h05); rx(8'h03); rx(8'h00);
        wait_idle("add_idle");
        expect_writes("add", 8'h08, 8'h00);
        check("add_en_pulses", en_cnt, 1);
        check("add_operands", {ALU_A, ALU_B}, 16'h0503);

        // MUL FF*FF then NOPER SUB reusing operands
        start_log();
        rx(8'hCC); rx(8'hFF); rx(8'hFF); rx(8'h02);
        wait_idle("mul_idle");
        expect_writes("mul", 8'h01, 8'hFE);
        start_log();
        rx(8'hDD); rx(8'h01);
        wait_idle("noper_idle");
        expect_writes("noper", 8'h00, 8'h00);
        check("noper_operands", {ALU_A, ALU_B, ALU_FUN}, 20'hFFFF1);

        // compare false: no OUT_VALID, timeout capture after TO wait cycles
        start_log();
        rx(8'hCC); rx(8'h03); rx(8'h05); rx(8'h0B);
        wait_idle("cmp_idle");
        expect_writes("cmp", 8'h00, 8'h00);
        check("cmp_clk_en_cycles", clken_cnt, 1 + TO);

        // FIFO full stall in SEND_LSB
        start_log();
        FIFO_FULL = 1'b1;
        rx(8'hCC); rx(8'h10); rx(8'h20); rx(8'h00);
        repeat (11) tick();
        check("full_no_writes", wlog.size(), 0);
        check("full_data_held", FIFO_WR_DATA, 8'h30);
        check("full_busy", CTRL_BUSY, 1);
        FIFO_FULL = 1'b0;
        wait_idle("full_idle");
        expect_writes("full", 8'h30, 8'h00);

        // reset in GET_B
        start_log();
        rx(8'hCC); rx(8'h07);
        check("pre_rst_a", ALU_A, 8'h07);
        #1 RST = 1'b0;
        #1;
        check("rst_async_a", ALU_A, 8'h00);
        check("rst_async_busy", CTRL_BUSY, 0);
        @(negedge CLK);
        #2 RST = 1'b1;
        tick();
        rx(8'hCC); rx(8'h02); rx(8'h02); rx(8'h00);
        wait_idle("post_rst_idle");
        expect_writes("post_rst", 8'h04, 8'h00);

        // stray bytes in IDLE and during ISSUE/WAIT/SEND
        start_log();
        rx(8'hAA); rx(8'h11);
        rx(8'hCC); rx(8'h01); rx(8'h02); rx(8'h00);
        rx(8'hCC); rx(8'hDD); rx(8'hCC); rx(8'h07);
        wait_idle("stray_idle");
        expect_writes("stray", 8'h03, 8'h00);
        check("stray_en_pulses", en_cnt, 1);
        check("stray_operands", {ALU_A, ALU_B}, 16'h0102);

        // random traffic
        repeat (3000) begin
            r = $urandom_range(0, 9);
            RX_D_VLD  = ($urandom_range(0, 2) == 0);
            RX_P_DATA = (r < 3) ? 8'hCC : (r < 5) ? 8'hDD : 8'($urandom_range(0, 255));
            FIFO_FULL = ($urandom_range(0, 3) == 0);
            spur      = ($urandom_range(0, 15) == 0);
            tick();
        end
        RX_D_VLD  = 1'b0;
        FIFO_FULL = 1'b0;
        spur      = 1'b0;
        tick();
        for (int i = 0; i < 3 && fq.size() != 0; i++) rx(8'h00);
        wait_idle("random_idle");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
